// File: rtl/rsa_pkg.sv
// -----------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the RSA datapath stages (entry conversion, exit
// conversion, Montgomery multiplier).
//   RSA_W     : operand width of the whole datapath
//   CNT_W     : width of the reduction-step counter
//   CNT_LAST  : counter value on the final reduction step
//   state_t   : FSM encoding shared by the pre- and post-processing stages
// -----------------------------------------------------------------------------
package rsa_pkg;

  localparam int RSA_W = 256;
  localparam int CNT_W = 8;

  // 256 steps are numbered 0..255; the step carrying this count is the last.
  localparam logic [CNT_W-1:0] CNT_LAST = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage : rsa_pkg

// File: rtl/mont_step.sv
// -----------------------------------------------------------------------------
// mont_step
// One combinational bit-serial Montgomery reduction step:
//   t_out = (t + (t[0] ? n : 0)) >> 1
// Adding the odd modulus when t is odd makes the sum even, so the shift is an
// exact division by two modulo n. Shared with the Montgomery multiplier.
// Ports:
//   t      in  [W:0]    running value (one guard bit above the operand)
//   n      in  [W-1:0]  modulus (must be odd for a meaningful result)
//   t_out  out [W:0]    reduced value
// -----------------------------------------------------------------------------
module mont_step
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic [W:0]   t,
  input  logic [W-1:0] n,
  output logic [W:0]   t_out
);

  logic [W:0] addend;
  logic [W:0] sum;

  // addend = t[0] ? {1'b0, n} : 0, built bit by bit so the mux is a plain AND.
  assign addend[W] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_mask
      assign addend[gi] = n[gi] & t[0];
    end
  endgenerate

  // With t < n on entry, t + n < 2n < 2^(W+1): the sum never overflows W+1 bits.
  assign sum   = t + addend;
  assign t_out = sum >> 1;

endmodule : mont_step

// File: rtl/post_processing.sv
// -----------------------------------------------------------------------------
// post_processing
// Exit stage of the RSA datapath: converts an operand out of the Montgomery
// domain, S = A * 2^-256 mod N, with one reduction step per clock followed by
// a single conditional subtract.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous reset, active high (the name is historical)
//   start  in   request pulse, sampled only while idle
//   A      in   [255:0] Montgomery-domain operand, A < N, sampled on accept
//   N      in   [255:0] odd modulus, held stable from accept until ready
//   S      out  [255:0] registered result, held until the next completion
//   ready  out  one-cycle completion pulse
//   busy   out  high from the accepting edge until the completion edge
// Latency: 257 clocks from the accepting edge to ready (256 steps + FIX).
// -----------------------------------------------------------------------------
module post_processing
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] S,
  output logic             ready,
  output logic             busy
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_reg, state_next;
  logic [WIDTH:0]     t_reg,     t_next;
  logic [CNT_W-1:0]   cnt_reg,   cnt_next;
  logic [WIDTH-1:0]   s_reg,     s_next;
  logic               ready_reg, ready_next;
  logic               busy_reg,  busy_next;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     t_step;
  logic [WIDTH:0]     n_ext;
  logic               t_ge_n;
  logic [WIDTH-1:0]   t_sub;

  mont_step #(
    .W (WIDTH)
  ) u_mont_step (
    .t     (t_reg),
    .n     (N),
    .t_out (t_step)
  );

  // The loop keeps T < 2N, so one compare/subtract at full T width
  // brings the result into [0, N).
  assign n_ext  = {1'b0, N};
  assign t_ge_n = (t_reg >= n_ext);

  // Only the low WIDTH bits of T - N are kept; whenever T >= N the difference
  // is below N, so dropping the guard bit loses nothing.
  assign t_sub  = t_reg[WIDTH-1:0] - N;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg <= IDLE;
      t_reg     <= '0;
      cnt_reg   <= '0;
      s_reg     <= '0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
      cnt_reg   <= cnt_next;
      s_reg     <= s_next;
      ready_reg <= ready_next;
      busy_reg  <= busy_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    cnt_next   = cnt_reg;
    s_next     = s_reg;
    ready_next = 1'b0;
    busy_next  = busy_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          t_next     = {1'b0, A};
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = LOOP;
        end
      end

      LOOP: begin
        t_next   = t_step;
        // Natural 8-bit wrap: 255 -> 0 coincides with leaving LOOP.
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) begin
          state_next = FIX;
        end
      end

      FIX: begin
        s_next     = t_ge_n ? t_sub : t_reg[WIDTH-1:0];
        ready_next = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign S     = s_reg;
  assign ready = ready_reg;
  assign busy  = busy_reg;

endmodule : post_processing

// File: tb/tb_post_processing.sv
// -----------------------------------------------------------------------------
// tb_post_processing
// Self-checking bench for post_processing. Expected results are pushed to a
// scoreboard queue when a request is driven and popped when ready is seen.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_post_processing;

  localparam int W       = 256;
  localparam int LAT     = 257;
  localparam int TIMEOUT = 700;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] n_in;
  logic [W-1:0] s_out;
  logic         ready;
  logic         busy;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  post_processing dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a_in),
    .N     (n_in),
    .S     (s_out),
    .ready (ready),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Helpers (stimulus and reference arithmetic only)
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] rand256();
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Entry-stage reference: M * 2^256 mod N by 256 modular doublings.
  function automatic logic [W-1:0] to_mont(input logic [W-1:0] m, input logic [W-1:0] n);
    logic [W:0] v;
    logic [W:0] n_e;
    n_e = {1'b0, n};
    v   = {1'b0, m};
    for (int i = 0; i < W; i++) begin
      v = v << 1;
      if (v >= n_e) v = v - n_e;
    end
    return v[W-1:0];
  endfunction

  // Called on a falling edge; the next rising edge is the accepting edge.
  // Returns on the falling edge right after it.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] n,
                             input logic [W-1:0] exp_s);
    a_in  = a;
    n_in  = n;
    start = 1'b1;
    exp_q.push_back(exp_s);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes one operation from the falling edge after the accepting edge.
  // lat counts edges from the accepting edge to the first ready sample (0 on
  // timeout). extra: cycles to keep watching after ready. pulse_at: cycle at
  // which a stray start is pulsed (-1 for none).
  task automatic collect(input int extra, input int pulse_at,
                         output logic [W-1:0] s, output int lat,
                         output int busy_cnt, output int ready_cnt,
                         output int overlap);
    int cyc;
    cyc       = 0;
    s         = '0;
    lat       = 0;
    busy_cnt  = 0;
    ready_cnt = 0;
    overlap   = 0;
    if (busy) busy_cnt++;
    while (cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
      if (cyc == pulse_at) begin
        start = 1'b1;
        a_in  = 256'd7;
      end else if (pulse_at > 0 && cyc == pulse_at + 1) begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (ready) begin
        ready_cnt++;
        if (busy) overlap++;
        if (lat == 0) begin
          lat = cyc;
          s   = s_out;
        end
      end
      if (lat != 0 && cyc >= lat + extra) break;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    a_in  = '0;
    n_in  = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (s_out !== '0) begin n_fail++; $display("FAIL reset_s got %h want 0", s_out); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    $display("reset: S=%h ready=%b busy=%b", s_out, ready, busy);
  endtask

  task automatic test_basic();
    logic [W-1:0] s, e;
    int lat, bc, rc, ov;
    drive_start(256'd3, 256'd13, 256'd1);
    collect(5, -1, s, lat, bc, rc, ov);
    e = exp_q.pop_front();
    $display("basic: A=3 N=13 S=%0h lat=%0d busy_cycles=%0d", s, lat, bc);
    n_checks++; if (s !== e) begin n_fail++; $display("FAIL basic_s got %h want %h", s, e); end
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
    n_checks++; if (bc !== LAT) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want %0d", bc, LAT); end
    n_checks++; if (rc !== 1) begin n_fail++; $display("FAIL basic_ready_pulses got %0d want 1", rc); end
    n_checks++; if (ov !== 0) begin n_fail++; $display("FAIL basic_ready_busy_overlap got %0d want 0", ov); end
    n_checks++; if (s_out !== e) begin n_fail++; $display("FAIL basic_s_hold got %h want %h", s_out, e); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s, e;
    int lat, bc, rc, ov;
    logic rdy_at_issue;
    drive_start(256'd1, 256'd13, 256'd9);
    collect(0, -1, s, lat, bc, rc, ov);
    e = exp_q.pop_front();
    $display("b2b first: A=1 N=13 S=%0h lat=%0d", s, lat);
    n_checks++; if (s !== e) begin n_fail++; $display("FAIL b2b_first_s got %h want %h", s, e); end
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL b2b_first_latency got %0d want %0d", lat, LAT); end
    // Still on the falling edge where ready is high: issue the next request now.
    rdy_at_issue = ready;
    drive_start(256'd0, 256'd13, 256'd0);
    n_checks++; if (rdy_at_issue !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_at_issue got %b want 1", rdy_at_issue); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy got %b want 1", busy); end
    collect(2, -1, s, lat, bc, rc, ov);
    e = exp_q.pop_front();
    $display("b2b second: A=0 N=13 S=%0h lat=%0d", s, lat);
    n_checks++; if (s !== e) begin n_fail++; $display("FAIL b2b_second_s got %h want %h", s, e); end
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL b2b_second_latency got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_carry();
    logic [W-1:0] s, e, n;
    int lat, bc, rc, ov;
    n = '1;
    drive_start(256'd5, n, 256'd5);
    collect(1, -1, s, lat, bc, rc, ov);
    e = exp_q.pop_front();
    $display("carry: A=5 N=2^256-1 S=%h lat=%0d", s, lat);
    n_checks++; if (s !== e) begin n_fail++; $display("FAIL carry_s got %h want %h", s, e); end
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL carry_latency got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_round_trip();
    logic [W-1:0] s, e, n, m, v;
    int lat, bc, rc, ov;
    for (int it = 0; it < 50; it++) begin
      n = rand256();
      n[W-1] = 1'b1;
      n[0]   = 1'b1;
      m = rand256();
      if (m >= n) m = m - n;
      v = to_mont(m, n);
      drive_start(v, n, m);
      collect(1, -1, s, lat, bc, rc, ov);
      e = exp_q.pop_front();
      $display("round_trip %0d: N=%h M=%h S=%h lat=%0d", it, n, m, s, lat);
      n_checks++; if (s !== e) begin n_fail++; $display("FAIL round_trip_%0d_s got %h want %h", it, s, e); end
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL round_trip_%0d_latency got %0d want %0d", it, lat, LAT); end
    end
  endtask

  task automatic test_ignored_start();
    logic [W-1:0] s, e;
    int lat, bc, rc, ov;
    drive_start(256'd3, 256'd13, 256'd1);
    // Start pulsed so that the edge of step 100 samples it.
    collect(300, 99, s, lat, bc, rc, ov);
    e = exp_q.pop_front();
    $display("ignored_start: S=%0h lat=%0d ready_pulses=%0d busy_cycles=%0d", s, lat, rc, bc);
    n_checks++; if (s !== e) begin n_fail++; $display("FAIL ignored_s got %h want %h", s, e); end
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL ignored_latency got %0d want %0d", lat, LAT); end
    n_checks++; if (rc !== 1) begin n_fail++; $display("FAIL ignored_ready_pulses got %0d want 1", rc); end
    n_checks++; if (bc !== LAT) begin n_fail++; $display("FAIL ignored_busy_cycles got %0d want %0d", bc, LAT); end
    n_checks++; if (s_out !== e) begin n_fail++; $display("FAIL ignored_s_hold got %h want %h", s_out, e); end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] s, e;
    int lat, bc, rc, ov;
    drive_start(256'd1, 256'd13, 256'd9);
    repeat (127) @(negedge clk);
    rst_n = 1'b1;
    #1;
    $display("mid_reset: S=%h ready=%b busy=%b", s_out, ready, busy);
    n_checks++; if (s_out !== '0) begin n_fail++; $display("FAIL mid_reset_s got %h want 0", s_out); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready got %b want 0", ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy got %b want 0", busy); end
    // The aborted request never completes.
    void'(exp_q.pop_front());
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_idle_busy got %b want 0", busy); end
    drive_start(256'd1, 256'd13, 256'd9);
    collect(1, -1, s, lat, bc, rc, ov);
    e = exp_q.pop_front();
    $display("after_reset: A=1 N=13 S=%0h lat=%0d", s, lat);
    n_checks++; if (s !== e) begin n_fail++; $display("FAIL after_reset_s got %h want %h", s, e); end
    n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL after_reset_latency got %0d want %0d", lat, LAT); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_carry();
    test_round_trip();
    test_ignored_start();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_post_processing
